sunrise_sequencer: RTL and testbench
====================================

Name: sunrise_sequencer

Overview:
Frame-rate controller that drives the `fade_level` and `direction` inputs of the `sunrise` sun renderer and sky fade logic. It steps a day cycle once per frame: night hold, rise, day hold, set, then back to night.
- All outputs change only on a start-of-frame strobe, so the renderer never sees a mid-frame change.
- Sits beside the VGA timing generator in the `clk_pix` domain.

Parameters:
- FRAMES_PER_STEP, 4, frames between successive fade steps in RISE/SET (1..65535).
- STEP_SIZE, 1, fade increment/decrement per step (1..255).
- DAY_FRAMES, 120, frames held at full brightness in DAY (1..65535).
- NIGHT_FRAMES, 60, frames held at zero brightness in NIGHT (1..65535).

Ports:
- clk_pix  input  1  pixel clock; the only clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- frame  input  1  single-cycle strobe, first cycle of vertical blanking.
- run  input  1  1 = sequence advances; 0 = freeze all state, `frame` ignored.
- restart  input  1  synchronous; returns all state to reset values on the next edge.
- fade_level  output  8  brightness/position index to `sunrise`; registered.
- direction  output  1  0 = sunrise half, 1 = sunset half; registered.
- phase  output  2  current state: NIGHT=0, RISE=1, DAY=2, SET=3.
- cycle_done  output  1  one-cycle pulse on the SET->NIGHT transition.

Behaviour:
- Reset (rst_n=0, async) sets: fade_level=0, direction=0, phase=NIGHT, cycle_done=0, step counter=0, hold counter=0.
- Priority on each edge: restart first, then run=0 (hold everything, cycle_done forced 0), then frame-driven advance. restart and frame in the same cycle: restart wins and the frame is dropped.
- Event definitions:
  - An "advance" is a cycle with run=1, frame=1, restart=0. Every state update happens on the edge that samples an advance, so outputs are valid the next cycle (1-cycle latency).
  - A "step" is an advance where step_cnt==FRAMES_PER_STEP-1. On a step, step_cnt clears; otherwise it increments. step_cnt only runs in RISE and SET and is cleared on entry to either.
- NIGHT: fade_level=0, direction=1. On each advance hold_cnt increments. On an advance with hold_cnt==NIGHT_FRAMES-1: go to RISE, set direction=0, clear hold_cnt and step_cnt.
- RISE: on each step, fade_level = min(fade_level+STEP_SIZE, 255). Do the addition 9 bits wide and saturate; never wrap. When the result equals 255, go to DAY on that same edge with hold_cnt=0.
- DAY: fade_level=255, direction=0. On an advance with hold_cnt==DAY_FRAMES-1: go to SET, set direction=1, clear step_cnt.
- SET: on each step, fade_level = max(fade_level-STEP_SIZE, 0), saturating. When the result equals 0, go to NIGHT, pulse cycle_done for exactly one cycle, clear hold_cnt.
- Direction after the first cycle: the first NIGHT after reset has direction=0 (reset value). Every later NIGHT has direction=1, which keeps the sun hidden.
- hold_cnt is 16 bits; step_cnt is $clog2(FRAMES_PER_STEP+1) bits. Neither counter may wrap within legal parameter ranges.
- frame asserted for more than one cycle: each asserted cycle counts as one advance. Upstream guarantees a single-cycle strobe.
- Any out-of-range phase encoding recovers to NIGHT with fade_level=0 on the next edge.

Decomposition:
- Shared package `sunrise_pkg`:
  - phase encoding constants NIGHT/RISE/DAY/SET (2-bit);
  - FADE_MAX=255 and FADE_MIN=0;
  - `sunrise`'s window thresholds 64/113/239, for benches to check sun visibility.
- One sub-module, `frame_divider`: a parameterised modulo-N frame counter with clear and enable, emitting the step pulse. Instantiate it for step_cnt only. hold_cnt stays inline because its terminal count depends on phase.

Test Plan:
- Reset/NIGHT: rst_n low mid-RISE with fade_level=128 -> next sample shows fade_level=0, direction=0, phase=0, cycle_done=0. Release rst_n, then NIGHT_FRAMES=2 advances -> phase=1 after the 2nd strobe.
- RISE saturation (FRAMES_PER_STEP=2, STEP_SIZE=64): fade_level goes 64, 128, 192, 255 on strobes 2, 4, 6, 8 of RISE. phase=2 on the same edge that produces 255; never 0 after 192.
- DAY to SET to NIGHT (DAY_FRAMES=3, same step params): after 3 advances in DAY, direction=1 and phase=3. fade_level goes 191, 127, 63, 0. cycle_done=1 for exactly one cycle coincident with phase becoming 0.
- Pause: run=0 for 10 strobes during RISE at fade_level=128 -> fade_level, phase and counters unchanged. With run=1, the next step resumes from the saved step_cnt.
- restart+frame in the same cycle during DAY -> next cycle phase=0, fade_level=0, direction=0, hold_cnt=0; no advance is counted.
- Default parameters: run one full cycle -> 255 RISE steps, 255 SET steps, total frame count = 60+1020+120+1020. cycle_done pulses once, and fade_level changes only in cycles following a frame strobe.

Source files
------------

// File: rtl/sunrise_pkg.sv
// Shared definitions for the sunrise day-cycle sequencer and the sun renderer:
// phase encoding, brightness limits and the renderer's sun-window thresholds.
package sunrise_pkg;

    typedef enum logic [1:0] {
        NIGHT = 2'd0,
        RISE  = 2'd1,
        DAY   = 2'd2,
        SET   = 2'd3
    } phase_e;

    localparam logic [7:0] FADE_MAX = 8'd255;
    localparam logic [7:0] FADE_MIN = 8'd0;

    // Fade levels at which the sunrise renderer's sun window changes shape.
    localparam logic [7:0] SUN_WIN_LO  = 8'd64;
    localparam logic [7:0] SUN_WIN_MID = 8'd113;
    localparam logic [7:0] SUN_WIN_HI  = 8'd239;

    function automatic logic [7:0] fade_sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? FADE_MAX : sum[7:0];
    endfunction

    function automatic logic [7:0] fade_sat_sub(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[8] ? FADE_MIN : diff[7:0];
    endfunction

endpackage

// File: rtl/sunrise_sequencer_if.sv
// Control/status bundle between the frame-timing side and the sunrise sequencer.
interface sunrise_sequencer_if;

    logic       frame;
    logic       run;
    logic       restart;
    logic [7:0] fade_level;
    logic       direction;
    logic [1:0] phase;
    logic       cycle_done;

    modport master (
        output frame, run, restart,
        input  fade_level, direction, phase, cycle_done
    );

    modport slave (
        input  frame, run, restart,
        output fade_level, direction, phase, cycle_done
    );

endinterface

// File: rtl/frame_divider.sv
// Modulo-N frame counter: emits a tick on the enabled frame that completes N frames.
module frame_divider #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = $clog2(N + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == W'(N - 1));

    // Clear outranks enable so a restart or phase entry always lands on zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)       cnt_d = '0;
        else if (tick) cnt_d = '0;
        else if (en)   cnt_d = cnt_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sunrise_sequencer.sv
// Day-cycle controller for the sunrise renderer: steps NIGHT/RISE/DAY/SET once
// per frame strobe so fade_level and direction only move during vertical blanking.
module sunrise_sequencer
    import sunrise_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 4,
    parameter int STEP_SIZE       = 1,
    parameter int DAY_FRAMES      = 120,
    parameter int NIGHT_FRAMES    = 60
) (
    input  logic                clk_pix,
    input  logic                rst_n,
    sunrise_sequencer_if.slave  bus
);

    localparam logic [15:0] NIGHT_LAST = 16'(NIGHT_FRAMES - 1);
    localparam logic [15:0] DAY_LAST   = 16'(DAY_FRAMES - 1);
    localparam logic [7:0]  STEP       = 8'(STEP_SIZE);

    phase_e      phase_q, phase_d;
    logic [7:0]  fade_q, fade_d;
    logic        dir_q, dir_d;
    logic        done_q, done_d;
    logic [15:0] hold_q, hold_d;

    logic advance;
    logic step_en;
    logic step_clr;
    logic step_tick;

    assign advance = bus.run && bus.frame && !bus.restart;
    assign step_en = advance && (phase_q == RISE || phase_q == SET);

    // The step counter restarts whenever a ramp phase is entered.
    assign step_clr = bus.restart
                   || (advance && phase_q == NIGHT && hold_q == NIGHT_LAST)
                   || (advance && phase_q == DAY   && hold_q == DAY_LAST);

    frame_divider #(
        .N (FRAMES_PER_STEP)
    ) u_step_div (
        .clk   (clk_pix),
        .rst_n (rst_n),
        .clr   (step_clr),
        .en    (step_en),
        .tick  (step_tick)
    );

    // NOTE: every next-state signal takes a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        phase_d = phase_q;
        fade_d  = fade_q;
        dir_d   = dir_q;
        hold_d  = hold_q;
        done_d  = 1'b0;

        if (bus.restart) begin
            phase_d = NIGHT;
            fade_d  = FADE_MIN;
            dir_d   = 1'b0;
            hold_d  = '0;
        end else if (bus.run && bus.frame) begin
            case (phase_q)
                NIGHT: begin
                    fade_d = FADE_MIN;
                    if (hold_q == NIGHT_LAST) begin
                        phase_d = RISE;
                        dir_d   = 1'b0;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 16'd1;
                    end
                end
                RISE: begin
                    if (step_tick) begin
                        fade_d = fade_sat_add(fade_q, STEP);
                        if (fade_d == FADE_MAX) begin
                            phase_d = DAY;
                            hold_d  = '0;
                        end
                    end
                end
                DAY: begin
                    fade_d = FADE_MAX;
                    if (hold_q == DAY_LAST) begin
                        phase_d = SET;
                        dir_d   = 1'b1;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 16'd1;
                    end
                end
                SET: begin
                    if (step_tick) begin
                        fade_d = fade_sat_sub(fade_q, STEP);
                        if (fade_d == FADE_MIN) begin
                            phase_d = NIGHT;
                            done_d  = 1'b1;
                            hold_d  = '0;
                        end
                    end
                end
                default: begin
                    phase_d = NIGHT;
                    fade_d  = FADE_MIN;
                end
            endcase
        end
    end

    // NOTE: only control state is reset here; there is no storage array, so
    // every flop in the block has a defined reset value.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= NIGHT;
            fade_q  <= FADE_MIN;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            phase_q <= phase_d;
            fade_q  <= fade_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.fade_level = fade_q;
    assign bus.direction  = dir_q;
    assign bus.phase      = phase_q;
    assign bus.cycle_done = done_q;

endmodule

// File: tb/tb_sunrise_sequencer.sv
// Directed bench: a small-parameter instance for the phase walk-through and a
// default-parameter instance run through one complete day cycle.
module tb_sunrise_sequencer;

    import sunrise_pkg::*;

    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    sunrise_sequencer_if s_if ();
    sunrise_sequencer_if d_if ();

    sunrise_sequencer #(
        .FRAMES_PER_STEP (2),
        .STEP_SIZE       (64),
        .DAY_FRAMES      (3),
        .NIGHT_FRAMES    (2)
    ) dut_s (
        .clk_pix (clk),
        .rst_n   (rst_n),
        .bus     (s_if)
    );

    sunrise_sequencer dut_d (
        .clk_pix (clk),
        .rst_n   (rst_n),
        .bus     (d_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame strobe on the small instance; returns at the sampling negedge.
    task automatic adv_s(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) s_if.frame = 1'b1;
            @(negedge clk) s_if.frame = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected fade after each RISE / SET advance with 2 frames per step of 64.
    logic [7:0] rise_exp [8] = '{8'd0, 8'd64, 8'd64, 8'd128, 8'd128, 8'd192, 8'd192, 8'd255};
    logic [7:0] set_exp  [8] = '{8'd255, 8'd191, 8'd191, 8'd127, 8'd127, 8'd63, 8'd63, 8'd0};

    initial begin
        int frames, rise_steps, set_steps, done_cnt, done_frame, bad_change;
        logic [7:0] prev;

        rst_n = 1'b0;
        s_if.frame = 1'b0; s_if.run = 1'b1; s_if.restart = 1'b0;
        d_if.frame = 1'b0; d_if.run = 1'b0; d_if.restart = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_fade", 32'(s_if.fade_level), 32'd0);
        check("rst_phase", 32'(s_if.phase), 32'(NIGHT));
        check("rst_dir", 32'(s_if.direction), 32'd0);
        check("rst_done", 32'(s_if.cycle_done), 32'd0);

        // Walk into RISE up to fade 128, then pull reset asynchronously.
        adv_s(2);
        check("pre_rise_phase", 32'(s_if.phase), 32'(RISE));
        adv_s(4);
        check("pre_rise_fade128", 32'(s_if.fade_level), 32'd128);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_fade", 32'(s_if.fade_level), 32'd0);
        check("async_rst_dir", 32'(s_if.direction), 32'd0);
        check("async_rst_phase", 32'(s_if.phase), 32'(NIGHT));
        check("async_rst_done", 32'(s_if.cycle_done), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        adv_s(1);
        check("night_hold1", 32'(s_if.phase), 32'(NIGHT));
        adv_s(1);
        check("night_to_rise", 32'(s_if.phase), 32'(RISE));
        check("rise_dir", 32'(s_if.direction), 32'd0);

        // RISE advances 1..5, pause with step counter at 1, then 6..8.
        for (int k = 0; k < 5; k++) begin
            adv_s(1);
            check($sformatf("rise_fade_%0d", k + 1), 32'(s_if.fade_level), 32'(rise_exp[k]));
            check($sformatf("rise_phase_%0d", k + 1), 32'(s_if.phase), 32'(RISE));
        end
        s_if.run = 1'b0;
        adv_s(10);
        check("pause_fade", 32'(s_if.fade_level), 32'd128);
        check("pause_phase", 32'(s_if.phase), 32'(RISE));
        s_if.run = 1'b1;
        for (int k = 5; k < 8; k++) begin
            adv_s(1);
            check($sformatf("rise_fade_%0d", k + 1), 32'(s_if.fade_level), 32'(rise_exp[k]));
            check($sformatf("rise_phase_%0d", k + 1), 32'(s_if.phase), (k == 7) ? 32'(DAY) : 32'(RISE));
        end

        adv_s(2);
        check("day_hold_phase", 32'(s_if.phase), 32'(DAY));
        check("day_hold_dir", 32'(s_if.direction), 32'd0);
        adv_s(1);
        check("day_to_set_phase", 32'(s_if.phase), 32'(SET));
        check("day_to_set_dir", 32'(s_if.direction), 32'd1);

        for (int k = 0; k < 8; k++) begin
            adv_s(1);
            check($sformatf("set_fade_%0d", k + 1), 32'(s_if.fade_level), 32'(set_exp[k]));
            check($sformatf("set_done_%0d", k + 1), 32'(s_if.cycle_done), (k == 7) ? 32'd1 : 32'd0);
        end
        check("cycle_phase", 32'(s_if.phase), 32'(NIGHT));
        @(negedge clk);
        check("cycle_done_once", 32'(s_if.cycle_done), 32'd0);
        check("night2_dir", 32'(s_if.direction), 32'd1);

        // Back to DAY, then restart collides with a frame strobe.
        adv_s(10);
        check("day2_phase", 32'(s_if.phase), 32'(DAY));
        adv_s(1);
        @(negedge clk) begin s_if.restart = 1'b1; s_if.frame = 1'b1; end
        @(negedge clk) begin s_if.restart = 1'b0; s_if.frame = 1'b0; end
        check("restart_phase", 32'(s_if.phase), 32'(NIGHT));
        check("restart_fade", 32'(s_if.fade_level), 32'd0);
        check("restart_dir", 32'(s_if.direction), 32'd0);
        adv_s(1);
        check("restart_hold1", 32'(s_if.phase), 32'(NIGHT));
        adv_s(1);
        check("restart_hold2", 32'(s_if.phase), 32'(RISE));

        // Full default-parameter cycle with two idle cycles between strobes.
        d_if.run = 1'b1;
        frames = 0; rise_steps = 0; set_steps = 0;
        done_cnt = 0; done_frame = 0; bad_change = 0;
        prev = d_if.fade_level;
        while (frames < 2400 && done_cnt == 0) begin
            @(negedge clk) d_if.frame = 1'b1;
            @(negedge clk) d_if.frame = 1'b0;
            frames++;
            if (d_if.fade_level > prev) rise_steps++;
            if (d_if.fade_level < prev) set_steps++;
            if (d_if.cycle_done) begin done_cnt++; done_frame = frames; end
            prev = d_if.fade_level;
            for (int g = 0; g < 2; g++) begin
                @(negedge clk);
                if (d_if.fade_level != prev) bad_change++;
                if (d_if.cycle_done) done_cnt++;
            end
        end
        check("dflt_total_frames", 32'(done_frame), 32'd2220);
        check("dflt_rise_steps", 32'(rise_steps), 32'd255);
        check("dflt_set_steps", 32'(set_steps), 32'd255);
        check("dflt_done_pulses", 32'(done_cnt), 32'd1);
        check("dflt_no_midframe_change", 32'(bad_change), 32'd0);
        check("dflt_end_phase", 32'(d_if.phase), 32'(NIGHT));
        check("dflt_end_dir", 32'(d_if.direction), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
